// File: rtl/mem_bd_pkg.sv
// Shared types for the memory backdoor controller: command opcodes, error codes, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_bd_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_FILL = 2'd1,
    OP_DUMP = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_NOT_HELD = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_ABORT    = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_FILL      = 3'd2,
    ST_DUMP_RD   = 3'd3,
    ST_DUMP_WAIT = 3'd4,
    ST_DUMP_OUT  = 3'd5,
    ST_FIN       = 3'd6
  } state_e;

endpackage

// File: rtl/mem_bd_checksum.sv
// Additive checksum accumulator (sum mod 2^DATA_W) with synchronous clear and add enable.
// Latency: sum reflects an add one cycle after add_en.
// Backpressure: none; accepts an add every cycle.
// Ports: clk, reset_n (sync, active-low), clr (clear, wins over add), add_en/add_val (accumulate), sum.
module mem_bd_checksum #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_val,
  output logic [DATA_W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_val;
    end
  end

endmodule

// File: rtl/mem_backdoor_ctrl.sv
// Backdoor loader/dumper for the system RAM: LOAD streams words in, FILL writes a pattern, DUMP streams words out.
// Latency: LOAD/FILL 1 word/cycle; DUMP 3 cycles/word (read, capture, present); done pulses in the cycle after the last word.
// Backpressure: cmd_ready low while busy; LOAD waits on wr_valid, DUMP holds rd_data until rd_ready, both unbounded.
// Ports: cmd_* command channel, wr_* LOAD data in, rd_* DUMP data out, mem_* spare RAM port (rdata 1 cycle after re),
//        cpu_hold gates all memory access, busy/done/err/checksum report status of the last command.
module mem_backdoor_ctrl
  import mem_bd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 65536,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_hold,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_fill,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [LEN_W:0] DEPTH_EXT = (LEN_W+1)'(DEPTH);

  state_e            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] rd_q;
  err_e              err_q;

  logic              accept;
  logic [LEN_W:0]    end_addr;
  logic              wr_beat;
  logic              fill_beat;
  logic              rd_beat;
  logic              sum_add;
  logic [DATA_W-1:0] sum_val;

  assign accept   = (state == ST_IDLE) && cmd_valid;
  // One bit wider than LEN_W so base+len = DEPTH is representable and accepted.
  assign end_addr = (LEN_W+1)'(cmd_base) + (LEN_W+1)'(cmd_len);

  // cpu_hold gates every beat combinationally: a beat in the cycle the hold drops is
  // neither written nor counted, and the FSM takes the abort at that same edge.
  assign wr_beat   = (state == ST_LOAD) && wr_valid && cpu_hold;
  assign fill_beat = (state == ST_FILL) && cpu_hold;
  assign rd_beat   = (state == ST_DUMP_OUT) && rd_ready && cpu_hold;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign err       = err_q;
  assign wr_ready  = (state == ST_LOAD) && cpu_hold;
  assign rd_valid  = (state == ST_DUMP_OUT) && cpu_hold;
  assign rd_data   = rd_q;
  assign mem_addr  = addr_q;
  // reset_n term keeps the strobes quiet during the reset cycle itself, not just after the edge.
  assign mem_we    = reset_n && (wr_beat || fill_beat);
  assign mem_re    = reset_n && cpu_hold && (state == ST_DUMP_RD);
  assign mem_wdata = (state == ST_LOAD) ? wr_data :
                     (state == ST_FILL) ? fill_q  : '0;

  assign sum_add = wr_beat || fill_beat || rd_beat;
  assign sum_val = wr_beat   ? wr_data :
                   fill_beat ? fill_q  : rd_q;

  mem_bd_checksum #(.DATA_W(DATA_W)) u_checksum (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .add_en  (sum_add),
    .add_val (sum_val),
    .sum     (checksum)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
      fill_q <= '0;
      rd_q   <= '0;
      err_q  <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_base;
            cnt_q  <= cmd_len;
            fill_q <= cmd_fill;
            err_q  <= ERR_OK;
            if (!cpu_hold) begin
              err_q <= ERR_NOT_HELD;
              state <= ST_FIN;
            end else if (end_addr > DEPTH_EXT) begin
              err_q <= ERR_RANGE;
              state <= ST_FIN;
            end else if (cmd_len == '0) begin
              state <= ST_FIN;
            end else begin
              case (op_e'(cmd_op))
                OP_LOAD: state <= ST_LOAD;
                OP_FILL: state <= ST_FILL;
                OP_DUMP: state <= ST_DUMP_RD;
                default: begin
                  err_q <= ERR_RANGE;
                  state <= ST_FIN;
                end
              endcase
            end
          end
        end

        ST_LOAD, ST_FILL, ST_DUMP_RD, ST_DUMP_WAIT, ST_DUMP_OUT: begin
          if (!cpu_hold) begin
            err_q <= ERR_ABORT;
            state <= ST_FIN;
          end else begin
            case (state)
              ST_LOAD, ST_FILL: begin
                if (state == ST_FILL || wr_valid) begin
                  addr_q <= addr_q + 1'b1;
                  cnt_q  <= cnt_q - 1'b1;
                  if (cnt_q == LEN_W'(1)) state <= ST_FIN;
                end
              end
              ST_DUMP_RD:   state <= ST_DUMP_WAIT;
              ST_DUMP_WAIT: begin
                rd_q  <= mem_rdata;
                state <= ST_DUMP_OUT;
              end
              default: begin
                if (rd_ready) begin
                  addr_q <= addr_q + 1'b1;
                  cnt_q  <= cnt_q - 1'b1;
                  state  <= (cnt_q == LEN_W'(1)) ? ST_FIN : ST_DUMP_RD;
                end
              end
            endcase
          end
        end

        default: state <= ST_IDLE;  // ST_FIN: done is high for exactly this cycle
      endcase
    end
  end

endmodule

// File: tb/tb_mem_backdoor_ctrl.sv
module tb_mem_backdoor_ctrl;

  logic        clk;
  logic        reset_n;
  logic        cpu_hold;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_base;
  logic [16:0] cmd_len;
  logic [7:0]  cmd_fill;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_data;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [7:0]  checksum;

  mem_backdoor_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_hold  (cpu_hold),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .cmd_fill  (cmd_fill),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .checksum  (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM behind the spare port: read data one cycle after mem_re.
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Transaction-level reference model.
  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  logic [7:0] mdl [0:65535];
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] words[$];
  logic [1:0] exp_err;
  logic [7:0] exp_sum;
  bit         expect_done;
  int         extra_we, extra_re, extra_rd, extra_done;
  int         n_checks, n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Single compare process against the model's expectation queues.
  wr_t        w_cur;
  bit         prev_done, prev_stall;
  logic [7:0] prev_rd;
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) extra_we++;
        else begin
          w_cur = exp_wr.pop_front();
          check("wr_addr", mem_addr, w_cur.addr);
          check("wr_data", mem_wdata, w_cur.data);
        end
      end
      if (mem_re && exp_rd.size() == 0) extra_re++;
      if (prev_stall && rd_valid) check("rd_hold", rd_data, prev_rd);
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) extra_rd++;
        else check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (done) begin
        if (!expect_done) extra_done++;
        else begin
          check("err", err, exp_err);
          check("checksum", checksum, exp_sum);
          check("busy_in_fin", busy, 1);
          expect_done = 0;
        end
      end
      if (prev_done) begin
        check("busy_after_done", busy, 0);
        check("cmd_ready_after_done", cmd_ready, 1);
      end
      prev_done  = done;
      prev_stall = rd_valid && !rd_ready;
      prev_rd    = rd_data;
    end else begin
      prev_done  = 0;
      prev_stall = 0;
    end
  end

  task automatic issue_cmd(input logic [1:0] op, input int base, input int len, input logic [7:0] fill);
    bit acc;
    cmd_op = op; cmd_base = 16'(base); cmd_len = 17'(len); cmd_fill = fill; cmd_valid = 1;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    check("cmd_accept", acc, 1);
  endtask

  // abort_after > 0 (LOAD only): drop cpu_hold after that many accepted beats.
  task automatic run_cmd(input logic [1:0] op, input int base, input int len, input logic [7:0] fill,
                         input int gap_pct, input bit rdy_pat, input int abort_after);
    int idx, k;
    bit got, aborting, hs;
    logic [7:0] d, s;
    while (words.size() < len + 1) words.push_back(8'($urandom_range(0, 255)));
    s = 0;
    exp_err = 0;
    if (!cpu_hold) exp_err = 1;
    else if (base + len > 65536) exp_err = 2;
    else if (len == 0) exp_err = 0;
    else if (op == 2'd3) exp_err = 2;
    else begin
      k = (op == 2'd0 && abort_after > 0) ? abort_after : len;
      for (int i = 0; i < k; i++) begin
        if (op == 2'd0) d = words[i];
        else if (op == 2'd1) d = fill;
        else d = mdl[base + i];
        if (op == 2'd2) exp_rd.push_back(d);
        else begin
          exp_wr.push_back('{base + i, d});
          mdl[base + i] = d;
        end
        s += d;
      end
      if (op == 2'd0 && abort_after > 0) exp_err = 3;
    end
    exp_sum = s;
    expect_done = 1;

    issue_cmd(op, base, len, fill);

    idx = 0; got = 0; aborting = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      if (aborting) begin
        cpu_hold = 0; wr_valid = 1; wr_data = words[idx];
      end else if (op == 2'd0 && idx < len) begin
        wr_valid = ($urandom_range(0, 99) >= gap_pct); wr_data = words[idx];
      end else wr_valid = 0;
      rd_ready = rdy_pat ? ((c % 4 == 0) || (c % 4 == 3)) : ($urandom_range(0, 1) == 1);
      @(negedge clk);
      hs  = wr_valid && wr_ready;
      got = done;
      @(posedge clk); #1;
      if (hs) begin
        idx++;
        if (abort_after > 0 && idx == abort_after) aborting = 1;
      end
    end
    check("done_seen", got, 1);
    wr_valid = 0; rd_ready = 0;
    if (aborting) cpu_hold = 1;
    check("writes_left", exp_wr.size(), 0);
    check("reads_left", exp_rd.size(), 0);
    check("extra_events", extra_we + extra_re + extra_rd + extra_done, 0);
    exp_wr.delete(); exp_rd.delete(); words.delete();
    extra_we = 0; extra_re = 0; extra_rd = 0; extra_done = 0;
  endtask

  initial begin
    int base, len, abort_n;
    logic [1:0] op;
    bit got;
    logic [7:0] v;

    n_checks = 0; n_pass = 0;
    extra_we = 0; extra_re = 0; extra_rd = 0; extra_done = 0;
    expect_done = 0;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom_range(0, 255));
      ram[i] = v; mdl[i] = v;
    end
    reset_n = 0; cpu_hold = 1; cmd_valid = 0; cmd_op = 0; cmd_base = 0; cmd_len = 0;
    cmd_fill = 0; wr_valid = 0; wr_data = 0; rd_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_checksum", checksum, 0);
    check("rst_strobes", {mem_we, mem_re, rd_valid, wr_ready}, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1 reset_n = 1;

    // LOAD back-to-back.
    words = {8'h11, 8'h22, 8'h33, 8'h44};
    run_cmd(2'd0, 16'h0010, 4, 8'h00, 0, 0, 0);
    check("load_sum_lit", checksum, 8'hAA);
    check("load_err_lit", err, 0);

    // FILL up to the top of memory, then one past it.
    run_cmd(2'd1, 16'hFFFC, 4, 8'hEA, 0, 0, 0);
    check("fill_sum_lit", checksum, 8'hA8);
    run_cmd(2'd1, 16'hFFFD, 4, 8'hEA, 0, 0, 0);
    check("fill_range_lit", err, 2);

    // DUMP with rd_ready pattern 1-0-0-1.
    run_cmd(2'd2, 16'h0010, 4, 8'h00, 0, 1, 0);
    check("dump_sum_lit", checksum, 8'hAA);

    // Not held, then zero length.
    cpu_hold = 0;
    run_cmd(2'd0, 16'h0020, 4, 8'h00, 0, 0, 0);
    check("not_held_lit", err, 1);
    cpu_hold = 1;
    run_cmd(2'd0, 16'h0020, 0, 8'h00, 0, 0, 0);
    check("len0_err_lit", err, 0);
    check("len0_sum_lit", checksum, 0);

    // Abort after 3 beats.
    words = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    run_cmd(2'd0, 16'h0040, 8, 8'h00, 0, 0, 3);
    check("abort_err_lit", err, 3);
    check("abort_sum_lit", checksum, 8'h60);

    // Randomized commands.
    for (int t = 0; t < 60; t++) begin
      op   = 2'($urandom_range(0, 3));
      base = ($urandom_range(0, 9) == 0) ? 65536 - int'($urandom_range(1, 12)) : int'($urandom_range(0, 48));
      len  = $urandom_range(0, 12);
      cpu_hold = ($urandom_range(0, 9) != 0);
      abort_n = (op == 2'd0 && cpu_hold && len > 2 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, len - 1)) : 0;
      run_cmd(op, base, len, 8'($urandom_range(0, 255)), $urandom_range(0, 50), 0, abort_n);
      cpu_hold = 1;
    end

    // Reset while a DUMP word is waiting in DUMP_OUT.
    for (int i = 0; i < 4; i++) exp_rd.push_back(mdl[16 + i]);
    expect_done = 0;
    rd_ready = 0;
    issue_cmd(2'd2, 16'h0010, 4, 8'h00);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = rd_valid;
      @(posedge clk); #1;
    end
    check("reach_dump_out", got, 1);
    reset_n = 0;
    @(negedge clk);
    check("rst_mid_strobes", {mem_we, mem_re}, 0);
    @(posedge clk); #1 reset_n = 1;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rd_valid", rd_valid, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_done", done, 0);
    check("rst_mid_checksum", checksum, 0);
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", extra_done, 0);
    exp_rd.delete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_backdoor_ctrl.md
Name: mem_backdoor_ctrl

Overview:
- Parametrised backdoor loader/dumper for the system RAM; the synthesizable, handshaked successor to the testbench memory-override interface.
- Sits between a host/bench command stream and a spare RAM port. Performs LOAD (stream words in), FILL (constant pattern), and DUMP (stream words out) over an address window.
- Operates only while the CPU core is held (cpu_hold=1). Reports a running additive checksum and an error code per command.

Parameters:
- DATA_W, 8, memory word width (bits)
- DEPTH, 65536, number of memory words
- ADDR_W, $clog2(DEPTH), address width
- LEN_W, ADDR_W+1, transfer length width (allows len = DEPTH)

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset, synchronous, active-low
- cpu_hold  input  1  1 = core held in reset; memory access permitted
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when cmd_valid&cmd_ready
- cmd_op  input  2  0=LOAD 1=FILL 2=DUMP 3=reserved
- cmd_base  input  ADDR_W  first word address
- cmd_len  input  LEN_W  word count
- cmd_fill  input  DATA_W  FILL pattern
- wr_valid / wr_ready  input / output  1 / 1  LOAD data handshake
- wr_data  input  DATA_W  LOAD word
- rd_valid / rd_ready  output / input  1 / 1  DUMP data handshake
- rd_data  output  DATA_W  DUMP word
- mem_addr  output  ADDR_W  RAM address
- mem_we  output  1  RAM write strobe
- mem_re  output  1  RAM read strobe
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, valid 1 cycle after mem_re
- busy  output  1  command in progress
- done  output  1  1-cycle pulse at command completion, including error completion
- err  output  2  0=OK 1=NOT_HELD 2=RANGE 3=ABORT; held until next accepted command
- checksum  output  DATA_W  sum mod 2^DATA_W of words transferred by last command

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE. All outputs 0 except cmd_ready=1. checksum=0, err=0.
- States: IDLE, LOAD, FILL, DUMP_RD, DUMP_WAIT, DUMP_OUT, FIN.
- IDLE: cmd_ready=1. On accept, latch base/len/fill, clear checksum and err.
  - cpu_hold=0 -> err=NOT_HELD, go to FIN.
  - base+len > DEPTH (computed at LEN_W+1 bits) -> err=RANGE, go to FIN.
  - len=0 -> go to FIN with err=OK, checksum=0.
  - op=3 -> err=RANGE, go to FIN.
  - Otherwise enter the op state, with addr=base and cnt=len.
- LOAD: wr_ready=1.
  - Each wr beat drives mem_we=1, mem_addr=addr, mem_wdata=wr_data in the same cycle (combinational pass-through, registered address). Then addr++, cnt--, checksum+=wr_data.
  - On the last beat, go to FIN. Throughput is 1 word/cycle.
- FILL: writes cmd_fill every cycle with mem_we=1, checksum+=fill, for len cycles, then FIN.
- DUMP_RD: mem_re=1, mem_addr=addr, then DUMP_WAIT.
- DUMP_WAIT: capture mem_rdata into the rd_data register, then DUMP_OUT.
- DUMP_OUT: rd_valid=1 with rd_data stable until rd_ready.
  - On handshake: checksum+=rd_data, addr++, cnt--. Go to DUMP_RD, or FIN if cnt reaches 0.
  - Maximum throughput is 1 word per 3 cycles; backpressure is unbounded.
- FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- busy=1 in every state except IDLE.
- cpu_hold falling in any active state: abort at that edge.
  - No further mem_we/mem_re; an in-flight wr beat in that cycle is not written.
  - err=ABORT, go to FIN. Checksum reflects completed words only.
- Address never wraps: range is checked up front, so addr=DEPTH-1 is the last access.
- cmd_valid while busy: cmd_ready=0, command held by host.
- wr_valid outside LOAD: ignored (wr_ready=0).
- Reset mid-operation: immediate return to IDLE on that edge. mem_we/mem_re are 0 from that cycle; no done pulse.

Decomposition:
- Shared package mem_bd_pkg:
  - op enum (OP_LOAD, OP_FILL, OP_DUMP)
  - err enum (ERR_OK, ERR_NOT_HELD, ERR_RANGE, ERR_ABORT)
  - state enum
- Sub-module mem_bd_checksum: accumulator with clear and add-enable. This is the only natural sub-module; everything else stays in one FSM.

Test Plan:
- cpu_hold=1, LOAD base=0x0010 len=4, data 0x11,0x22,0x33,0x44 back-to-back -> four mem_we cycles at 0x10..0x13, done pulse, err=0, checksum=0xAA.
- FILL base=0xFFFC len=4 fill=0xEA -> writes at 0xFFFC..0xFFFF, checksum=0xA8, err=0. Then FILL base=0xFFFD len=4 -> err=RANGE, no mem_we, done next cycle.
- DUMP base=0x0010 len=4 after the first test, rd_ready toggled 1-0-0-1 -> rd_data 0x11,0x22,0x33,0x44 in order, each held while stalled, checksum=0xAA.
- LOAD with cpu_hold=0 -> err=NOT_HELD, no mem_we. LOAD len=0 -> done with err=0, checksum=0.
- LOAD len=8, cpu_hold dropped after beat 3 -> exactly 3 writes, err=ABORT, checksum=sum of first 3 words.
- reset_n=0 during DUMP_OUT -> next cycle busy=0, rd_valid=0, cmd_ready=1, no done pulse.
